// File: rtl/execute_muldiv_ctrl.sv
// Iterative radix-2 sequencer for RV32M multiply/divide in the execute stage.
// Holds the pipeline while a 1-bit-per-cycle shift-add / restoring-divide runs.
module execute_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid_i,
    input  logic            mdu_op_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            div_by_zero_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] hi_q, lo_q, opa_q, res_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q, rem_neg_q, valid_q, dz_q;

    logic            start, is_div, s1, s2, na, nb, dz_in, ovf_in;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    assign start  = ex_valid_i & mdu_op_i & ~flush_i;
    assign is_div = funct3_i[2];
    assign s1 = (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                (funct3_i == 3'b100) | (funct3_i == 3'b110);
    assign s2 = (funct3_i == 3'b001) | (funct3_i == 3'b100) |
                (funct3_i == 3'b110);
    assign na    = s1 & data1[XLEN-1];
    assign nb    = s2 & data2[XLEN-1];
    assign mag_a = na ? -data1 : data1;
    assign mag_b = nb ? -data2 : data2;
    assign dz_in  = is_div & ~|data2;
    assign ovf_in = is_div & ~funct3_i[0] & &data2 &
                    (data1 == {1'b1, {(XLEN-1){1'b0}}});
    assign fast_res = dz_in ? (funct3_i[1] ? data1 : '1)
                            : (funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    logic [XLEN:0]     sum, sh, diff;
    logic [XLEN-1:0]   hi_n, lo_n, q_s, r_s, mul_res, div_res;
    logic [2*XLEN-1:0] prod_s;

    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
        sh   = {hi_q, lo_q[XLEN-1]};
        diff = sh - {1'b0, opa_q};
        hi_n = sum[XLEN:1];
        lo_n = {sum[0], lo_q[XLEN-1:1]};
        if (f3_q[2]) begin
            // Restoring step: keep the trial difference only if it did not borrow.
            hi_n = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], ~diff[XLEN]};
        end
        prod_s  = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        mul_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                       : prod_s[2*XLEN-1:XLEN];
        q_s     = neg_q ? -lo_n : lo_n;
        r_s     = rem_neg_q ? -hi_n : hi_n;
        div_res = f3_q[1] ? r_s : q_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            f3_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opa_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            valid_q   <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    f3_q      <= funct3_i;
                    neg_q     <= na ^ nb;
                    rem_neg_q <= na;
                    hi_q      <= '0;
                    cnt_q     <= CW'(XLEN-1);
                    opa_q     <= is_div ? mag_b : mag_a;
                    lo_q      <= is_div ? mag_a : mag_b;
                    dz_q      <= dz_in;
                    if (dz_in | ovf_in) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                        res_q   <= fast_res;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: if (flush_i) begin
                    state <= IDLE;
                end else begin
                    hi_q <= hi_n;
                    lo_q <= lo_n;
                    if (cnt_q == '0) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                        res_q   <= f3_q[2] ? div_res : mul_res;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A flush kills the hold and any pending result in the same cycle.
    assign stall_o = rst_n & ~flush_i &
                     (((state == IDLE) & start) | (state == CALC));
    assign busy_o         = (state != IDLE);
    assign result_valid_o = valid_q & ~flush_i;
    assign result_o       = res_q;
    assign div_by_zero_o  = dz_q & result_valid_o;

endmodule
